// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios PIO slaves: register word addresses and edge modes.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_sync.sv
// WIDTH x STAGES metastability flop chain with a parametrised reset value.
module nios_pio_sync #(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VALUE;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/nios_system_pio_in_irq.sv
// Avalon-MM input PIO: synchronised data register, per-bit edge capture,
// interrupt mask and a registered level IRQ.
module nios_system_pio_in_irq
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               EDGE_MODE   = 0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_next;
  logic             wr;
  logic             wdata_unused;

  nios_pio_sync #(
    .WIDTH       (WIDTH),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_in)
  );

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Bits of writedata above WIDTH have no destination.
  assign wdata_unused = &{1'b0, writedata};

  always_comb begin
    edge_det = sync_in & ~prev;
    case (EDGE_MODE)
      EDGE_FALL: edge_det = ~sync_in & prev;
      EDGE_ANY:  edge_det = sync_in ^ prev;
      default:   edge_det = sync_in & ~prev;
    endcase
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = sync_in;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= RESET_VALUE;
      edgecap  <= '0;
      irqmask  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= sync_in;
      // Clear first, then OR in new edges so a coincident edge is never lost.
      edgecap  <= (edgecap & ~clr) | edge_det;
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      readdata <= rd_next;
      irq      <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_nios_system_pio_in_irq.sv
// Directed bench: one rising-edge and one any-edge instance on a shared bus.
module tb_nios_system_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs_r, cs_a;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_r, in_a;
  logic [31:0] readdata_r, readdata_a;
  logic        irq_r, irq_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_irq #(.WIDTH(8), .EDGE_MODE(0), .SYNC_STAGES(2), .RESET_VALUE(8'h00)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_r), .write_n(write_n),
    .writedata(writedata), .in_port(in_r), .readdata(readdata_r), .irq(irq_r)
  );

  nios_system_pio_in_irq #(.WIDTH(8), .EDGE_MODE(2), .SYNC_STAGES(2), .RESET_VALUE(8'h00)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(readdata_a), .irq(irq_a)
  );

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  in_val;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic sel_r, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    cs_r      = sel_r;
    cs_a      = ~sel_r;
    write_n   = 1'b0;
    tick();
    cs_r      = 1'b0;
    cs_a      = 1'b0;
    write_n   = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'd0, 1'b0, 32'h0000_0000, 8'hA5, 32'h0000_00A5, 1'b0};
    vecs[1]  = '{2'd0, 1'b0, 32'h0000_0000, 8'h3C, 32'h0000_003C, 1'b0};
    vecs[2]  = '{2'd1, 1'b1, 32'hFFFF_FF00, 8'h3C, 32'h0000_0000, 1'b0};
    vecs[3]  = '{2'd3, 1'b1, 32'hFFFF_FFFF, 8'h3C, 32'h0000_0000, 1'b0};
    vecs[4]  = '{2'd0, 1'b1, 32'h0000_0000, 8'h3C, 32'h0000_003C, 1'b0};
    vecs[5]  = '{2'd2, 1'b0, 32'h0000_0000, 8'h3C, 32'h0000_00BD, 1'b0};
    vecs[6]  = '{2'd2, 1'b1, 32'h0000_00FF, 8'h3C, 32'h0000_0000, 1'b0};
    vecs[7]  = '{2'd1, 1'b1, 32'h0000_005A, 8'h3C, 32'h0000_005A, 1'b0};
    vecs[8]  = '{2'd0, 1'b0, 32'h0000_0000, 8'h3D, 32'h0000_003D, 1'b0};
    vecs[9]  = '{2'd2, 1'b1, 32'h0000_0001, 8'h3D, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'd2, 1'b0, 32'h0000_0000, 8'h7D, 32'h0000_0040, 1'b1};
    vecs[11] = '{2'd2, 1'b1, 32'h0000_0040, 8'h7D, 32'h0000_0000, 1'b0};

    reset = 1'b1; address = 2'd0; cs_r = 1'b0; cs_a = 1'b0; write_n = 1'b1;
    writedata = '0; in_r = 8'h00; in_a = 8'h00;
    tick(3);
    chk("reset_rd_r", readdata_r, 32'h0);
    chk("reset_irq_r", {31'b0, irq_r}, 32'h0);
    chk("reset_rd_a", readdata_a, 32'h0);
    chk("reset_irq_a", {31'b0, irq_a}, 32'h0);
    reset = 1'b0;
    tick(2);

    // Table: optional write on the first cycle, then hold address/input for 4 clks.
    for (int i = 0; i < 12; i++) begin
      in_r = vecs[i].in_val;
      if (vecs[i].wr) bus_write(1'b1, vecs[i].addr, vecs[i].wdata);
      else begin address = vecs[i].addr; tick(); end
      address = vecs[i].addr;
      tick(4);
      chk($sformatf("vec%0d_rd", i), readdata_r, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq_r}, {31'b0, vecs[i].exp_irq});
    end

    // Rising mode: falling edge ignored, then exact capture and irq latency.
    bus_write(1'b1, 2'd1, 32'h0000_0001);
    address = 2'd2;
    in_r = 8'h7C;
    tick(4);
    chk("fall_ignored", readdata_r, 32'h0);
    in_r = 8'h7D;
    tick(3);
    chk("lat_edge3_rd", readdata_r, 32'h0);
    chk("lat_edge3_irq", {31'b0, irq_r}, 32'h0);
    tick();
    chk("lat_edge4_rd", readdata_r, 32'h1);
    chk("lat_edge4_irq", {31'b0, irq_r}, 32'h1);
    bus_write(1'b1, 2'd2, 32'h0000_0001);
    address = 2'd2;
    tick();
    chk("clr_rd", readdata_r, 32'h0);
    chk("clr_irq", {31'b0, irq_r}, 32'h0);

    // Set wins: clear of bits 5 and 1 coincides with a new rising edge on bit 5.
    in_r = 8'h5D;
    tick(4);
    in_r = 8'h5F;
    tick(4);
    chk("pre_setwins", readdata_r, 32'h2);
    in_r = 8'h7F;
    tick(2);
    bus_write(1'b1, 2'd2, 32'h0000_0022);
    address = 2'd2;
    tick(2);
    chk("set_wins", readdata_r, 32'h20);
    chk("set_wins_irq", {31'b0, irq_r}, 32'h0);

    // Any-edge mode: pulse on bit 3 captured while masked, irq follows unmask.
    address = 2'd2;
    in_a = 8'h08;
    tick(4);
    in_a = 8'h00;
    tick(4);
    chk("any_cap", readdata_a, 32'h08);
    chk("any_masked_irq", {31'b0, irq_a}, 32'h0);
    bus_write(1'b0, 2'd1, 32'h0000_0008);
    chk("any_unmask_edge1", {31'b0, irq_a}, 32'h0);
    tick();
    chk("any_unmask_edge2", {31'b0, irq_a}, 32'h1);

    // Async reset with all capture bits set and irq high.
    bus_write(1'b0, 2'd1, 32'h0000_00FF);
    address = 2'd2;
    in_a = 8'hFF;
    tick(5);
    chk("pre_rst_rd", readdata_a, 32'hFF);
    chk("pre_rst_irq", {31'b0, irq_a}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rd_a", readdata_a, 32'h0);
    chk("async_rst_irq_a", {31'b0, irq_a}, 32'h0);
    chk("async_rst_rd_r", readdata_r, 32'h0);
    in_a = 8'h00;
    tick(2);
    reset = 1'b0;
    address = 2'd1;
    tick(4);
    chk("post_rst_mask", readdata_a, 32'h0);
    address = 2'd2;
    tick();
    chk("post_rst_edgecap", readdata_a, 32'h0);
    chk("post_rst_irq", {31'b0, irq_a}, 32'h0);
    bus_write(1'b0, 2'd3, 32'hDEAD_BEEF);
    address = 2'd3;
    tick(2);
    chk("reserved_rd", readdata_a, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
